// File: rtl/matrix_scan_scheduler.sv
`default_nettype none
// ===========================================================================
// matrix_scan_scheduler - double-buffered 16x16 2-bit LED matrix scan driver
// Revision: 1.0
// ===========================================================================
module matrix_scan_scheduler #(
  parameter int CLK_DIV = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [3:0] wr_x,
  input  logic [3:0] wr_y,
  input  logic [1:0] wr_level,
  input  logic       swap_req,
  output logic       swap_ack,
  output logic       frame_start,
  output logic       sclk,
  output logic       serial_data,
  output logic       rclk,
  output logic       clear
);

  localparam logic [15:0] DIV_MAX    = 16'(CLK_DIV - 1);
  localparam logic [6:0]  STEP_LATCH = 7'd64;
  localparam logic [6:0]  STEP_LAST  = 7'd65;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  init_cnt;
  logic [15:0] div_cnt;
  logic        tick;
  logic [6:0]  step;
  logic [3:0]  row;
  logic [1:0]  phase;
  logic        front_sel;   // 0: bank A is front, 1: bank B is front
  logic        pending;
  logic        swap_exec;
  logic        frame_end;

  logic [1:0]  bank_a [256];
  logic [1:0]  bank_b [256];

  logic [4:0]  bit_idx;
  logic [7:0]  rd_addr;
  logic [1:0]  rd_level;
  logic        data_bit;
  logic [7:0]  wr_addr;

  assign tick      = (state == ST_RUN) && (div_cnt == DIV_MAX);
  assign frame_end = (step == STEP_LAST) && (row == 4'd15) && (phase == 2'd3);
  assign swap_exec = tick && frame_end && pending;

  // Anode bit i shows column 15-i, i.e. the bitwise inverse of the low nibble.
  assign bit_idx  = step[5:1];
  assign rd_addr  = {row, ~bit_idx[3:0]};
  assign rd_level = front_sel ? bank_b[rd_addr] : bank_a[rd_addr];
  assign data_bit = bit_idx[4] ? (bit_idx[3:0] != row) : (rd_level > phase);
  assign wr_addr  = {wr_y, wr_x};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    wr_ready    = 1'b0;
    swap_ack    = 1'b0;
    frame_start = 1'b0;
    case (state)
      ST_INIT: begin
        if (init_cnt == 8'd255) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        wr_ready    = !swap_exec;
        swap_ack    = swap_exec;
        frame_start = tick && (step == 7'd0) && (row == 4'd0) && (phase == 2'd0);
      end
      default: state_next = ST_INIT;
    endcase
  end

  // Pixel storage has no reset; the INIT sweep clears both banks instead.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      bank_a[init_cnt] <= 2'd0;
      bank_b[init_cnt] <= 2'd0;
    end else if (wr_valid && wr_ready) begin
      if (front_sel) begin
        bank_a[wr_addr] <= wr_level;
      end else begin
        bank_b[wr_addr] <= wr_level;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_cnt    <= 8'd0;
      div_cnt     <= 16'd0;
      step        <= 7'd0;
      row         <= 4'd0;
      phase       <= 2'd0;
      front_sel   <= 1'b0;
      pending     <= 1'b0;
      sclk        <= 1'b0;
      rclk        <= 1'b0;
      serial_data <= 1'b0;
      clear       <= 1'b0;
    end else begin
      clear   <= 1'b1;
      pending <= swap_req || (pending && !swap_exec);
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + 8'd1;
        div_cnt  <= 16'd0;
      end else begin
        div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
      end
      if (tick) begin
        if (step < STEP_LATCH) begin
          sclk <= step[0];
          rclk <= 1'b0;
          if (!step[0]) begin
            serial_data <= data_bit;
          end
          step <= step + 7'd1;
        end else if (step == STEP_LATCH) begin
          rclk <= 1'b1;
          sclk <= 1'b0;
          step <= STEP_LAST;
        end else begin
          rclk <= 1'b0;
          step <= 7'd0;
          row  <= row + 4'd1;
          if (row == 4'd15) begin
            phase <= phase + 2'd1;
          end
          if (swap_exec) begin
            front_sel <= !front_sel;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_scheduler.sv
`default_nettype none
// ===========================================================================
// tb_matrix_scan_scheduler - scoreboard bench for matrix_scan_scheduler
// Revision: 1.0
// ===========================================================================
`timescale 1ns/1ps
module tb_matrix_scan_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, wr_valid, wr_ready, swap_req, swap_ack, frame_start;
  logic       sclk, serial_data, rclk, clear;
  logic [3:0] wr_x, wr_y;
  logic [1:0] wr_level;

  logic       rst2, wr_ready2, swap_ack2, frame_start2, sclk2, sd2, rclk2, clear2;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int ack_cnt  = 0;
  int rows_cmp = 0;
  bit done2    = 1'b0;

  typedef struct packed {
    logic [1:0]  phase;
    logic [3:0]  row;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  logic [1:0]  m_front [256];
  logic [1:0]  m_back  [256];
  logic [31:0] captured [4][16];
  logic [31:0] sh;
  logic        prev_sclk, prev_rclk;

  matrix_scan_scheduler #(.CLK_DIV(1)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_level(wr_level), .swap_req(swap_req),
    .swap_ack(swap_ack), .frame_start(frame_start), .sclk(sclk),
    .serial_data(serial_data), .rclk(rclk), .clear(clear)
  );

  matrix_scan_scheduler #(.CLK_DIV(4)) dut_div4 (
    .clk(clk), .rst(rst2), .wr_valid(1'b0), .wr_ready(wr_ready2),
    .wr_x(4'd0), .wr_y(4'd0), .wr_level(2'd0), .swap_req(1'b0),
    .swap_ack(swap_ack2), .frame_start(frame_start2), .sclk(sclk2),
    .serial_data(sd2), .rclk(rclk2), .clear(clear2)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Expected 32-bit row word: first-shifted bit lands in bit 31.
  task automatic push_frame();
    exp_t e;
    for (int p = 0; p < 4; p++) begin
      for (int r = 0; r < 16; r++) begin
        e.phase = 2'(p);
        e.row   = 4'(r);
        e.word  = '0;
        for (int i = 0; i < 16; i++) e.word[31-i] = (m_front[r*16 + 15 - i] > 2'(p));
        for (int k = 0; k < 16; k++) e.word[15-k] = (k != r);
        exp_q.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [1:0] t;
    exp_t       e;
    if (rst) begin
      sh        = '0;
      prev_sclk = 1'b0;
      prev_rclk = 1'b0;
      exp_q.delete();
      for (int a = 0; a < 256; a++) begin
        m_front[a] = 2'd0;
        m_back[a]  = 2'd0;
      end
    end else begin
      if (wr_valid && wr_ready) m_back[{wr_y, wr_x}] = wr_level;
      if (swap_ack) begin
        ack_cnt++;
        for (int a = 0; a < 256; a++) begin
          t = m_front[a]; m_front[a] = m_back[a]; m_back[a] = t;
        end
      end
      if (frame_start) push_frame();
      if (sclk && !prev_sclk) sh = {sh[30:0], serial_data};
      if (rclk && !prev_rclk) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL row_unexpected: actual %h required no latch", sh);
        end else begin
          e = exp_q.pop_front();
          rows_cmp++;
          captured[e.phase][e.row] = sh;
          if (sh !== e.word) begin
            errors++;
            $display("FAIL row_p%0d_r%0d: actual %h required %h", e.phase, e.row, sh, e.word);
          end
        end
      end
      prev_sclk = sclk;
      prev_rclk = rclk;
    end
  end

  task automatic release_and_init(input bit req_in_init);
    int n;
    n   = 0;
    rst = 1'b0;
    while (!wr_ready && n < 1000) begin
      n++;
      if (req_in_init) swap_req = (n == 10);
      @(posedge clk); #1;
      if (n == 1) check("clear_after_reset", 32'(clear), 32'd1);
    end
    swap_req = 1'b0;
    check("init_cycles", n, 256);
    check("frame_start_after_init", 32'(frame_start), 32'd1);
  endtask

  task automatic wait_evt(input bit want_ack, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      @(posedge clk); #1;
      if (want_ack ? swap_ack : frame_start) at = cyc;
    end
    check("event_seen", 32'(at >= 0), 32'd1);
  endtask

  task automatic wait_rise2(input bit sel_sclk, output int at);
    logic prev, cur;
    at = -1;
    @(negedge clk);
    prev = sel_sclk ? sclk2 : rclk2;
    for (int i = 0; i < 2000 && at < 0; i++) begin
      @(negedge clk);
      cur = sel_sclk ? sclk2 : rclk2;
      if (cur && !prev) at = cyc;
      prev = cur;
    end
    check("div4_edge_seen", 32'(at >= 0), 32'd1);
  endtask

  initial begin : div4_checks
    int t0, t1, s0, s1, n;
    rst2 = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst2 = 1'b0;
    wait_rise2(1'b0, t0);
    n = 0;
    while (rclk2 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("div4_rclk_high", n, 4);
    wait_rise2(1'b0, t1);
    check("div4_rclk_period", t1 - t0, 264);
    wait_rise2(1'b1, s0);
    wait_rise2(1'b1, s1);
    check("div4_sclk_period", s1 - s0, 8);
    done2 = 1'b1;
  end

  initial begin : stimulus
    int f1, a1, a2, f3, f4, a3;
    rst = 1'b1; wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_level = '0; swap_req = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("reset_outputs", {25'd0, sclk, rclk, serial_data, clear, wr_ready, swap_ack, frame_start}, 32'd0);
    release_and_init(1'b0);
    f1 = cyc;

    wr_valid = 1'b1; wr_x = 4'd15; wr_y = 4'd0; wr_level = 2'd2;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    swap_req = 1'b1;
    @(posedge clk); #1;
    swap_req = 1'b0;
    repeat (9) @(posedge clk); #1;
    swap_req = 1'b1;
    @(posedge clk); #1;
    swap_req = 1'b0;

    wait_evt(1'b1, 5000, a1);
    check("ack1_cycle", a1 - f1, 4223);
    check("wr_ready_in_swap", 32'(wr_ready), 32'd0);
    swap_req = 1'b1;
    @(posedge clk); #1;
    swap_req = 1'b0;
    check("frame_start_after_swap", 32'(frame_start), 32'd1);
    check("ack_count_1", ack_cnt, 1);

    // Written to back while frame 2 is shown; must only appear after the next swap.
    wr_valid = 1'b1; wr_x = 4'd3; wr_y = 4'd2; wr_level = 2'd3;
    @(posedge clk); #1;
    wr_valid = 1'b0;

    wait_evt(1'b1, 5000, a2);
    check("ack2_cycle", a2 - a1, 4224);
    check("row0_bit0_phase0", 32'(captured[0][0][31]), 32'd1);
    check("row0_bit0_phase1", 32'(captured[1][0][31]), 32'd1);
    check("row0_bit0_phase2", 32'(captured[2][0][31]), 32'd0);
    check("row0_bit0_phase3", 32'(captured[3][0][31]), 32'd0);
    check("row0_phase0_word", captured[0][0], 32'h8000_7FFF);
    check("row5_cathodes", 32'(captured[0][5][15:0]), 32'h0000_FBFF);

    @(posedge clk); #1;
    f3 = cyc;
    check("frame_start_frame3", 32'(frame_start), 32'd1);
    check("ack_count_2", ack_cnt, 2);

    while (cyc < f3 + 484) begin
      @(posedge clk); #1;
    end
    check("sclk_high_row7_bit10", 32'(sclk), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", {25'd0, sclk, rclk, serial_data, clear, wr_ready, swap_ack, frame_start}, 32'd0);
    repeat (3) @(posedge clk); #1;
    release_and_init(1'b1);
    f4 = cyc;

    wait_evt(1'b1, 5000, a3);
    check("ack3_cycle", a3 - f4, 4223);
    @(posedge clk); #1;
    check("rows_compared", rows_cmp, 199);
    check("ack_count_3", ack_cnt, 3);

    for (int i = 0; i < 1000 && !done2; i++) @(posedge clk);
    check("div4_done", 32'(done2), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
